// File: rtl/up_packet_controller_pkg.sv
// Shared types and constants for the uP packet controller: byte/cmd/state types,
// status word layout and packet sizes.
package up_packet_controller_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [7:0] {
    READ_REGISTER_CMD  = 8'd0,
    WRITE_REGISTER_CMD = 8'd1
  } cmd_e;

  typedef enum logic [2:0] {
    PktIdle,
    PktRx,
    PktExec,
    PktWaitBus,
    PktTx,
    PktDone
  } pkt_state_e;

  typedef enum logic [2:0] {
    LinkIdle,
    LinkRxWaitH1,
    LinkRxWaitH1Low,
    LinkTxDrive,
    LinkTxWaitAck,
    LinkTxWaitAckLow
  } link_state_e;

  localparam int unsigned StatusBusErrBit = 0;
  localparam int unsigned StatusBadCmdBit = 1;

  localparam int unsigned NOS_READ_BYTES_FROM_UP = 6;
  localparam int unsigned NOS_WRITE_BYTES_TO_UP  = 8;

  // {count, cmd echo, address echo, 6'b0, BAD_CMD, BUS_ERR}
  function automatic logic [31:0] make_status(input logic  bus_err,
                                              input logic  bad_cmd,
                                              input byte_t addr,
                                              input byte_t cmd,
                                              input byte_t count);
    logic [31:0] s;
    s = {count, cmd, addr, 8'h00};
    s[StatusBusErrBit] = bus_err;
    s[StatusBadCmdBit] = bad_cmd;
    return s;
  endfunction

endpackage

// File: rtl/up_packet_controller_byte_link.sv
// Per-byte uP handshake engine: receives one byte (RX) or presents one byte (TX)
// using handshake_1/handshake_2, and reports completion to the packet sequencer.
module up_packet_controller_byte_link
  import up_packet_controller_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_abort,
  input  logic  i_byte_go,
  input  logic  i_dir_tx,
  input  byte_t i_tx_byte,
  input  logic  i_handshake_1,
  input  logic  i_rw,
  output logic  o_rx_valid,
  output logic  o_byte_done,
  output logic  o_handshake_2,
  output byte_t o_data_out,
  output logic  o_data_oe
);

  link_state_e r_state, w_state_next;
  logic        r_hs2, w_hs2_next;
  logic        w_tx_phase;

  assign w_tx_phase = r_state inside {LinkTxDrive, LinkTxWaitAck, LinkTxWaitAckLow};

  assign o_rx_valid  = !i_abort && (r_state == LinkRxWaitH1) && i_handshake_1 && i_rw;
  assign o_byte_done = !i_abort && !i_handshake_1 &&
                       ((r_state == LinkRxWaitH1Low) || (r_state == LinkTxWaitAckLow));

  assign o_handshake_2 = r_hs2;
  // RW high means the uP is driving the pins, so release them in the same cycle.
  assign o_data_oe     = w_tx_phase && !i_rw;
  assign o_data_out    = w_tx_phase ? i_tx_byte : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LinkIdle;
      r_hs2   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hs2   <= w_hs2_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hs2_next   = r_hs2;
    if (i_abort) begin
      w_state_next = LinkIdle;
      w_hs2_next   = 1'b0;
    end else begin
      unique case (r_state)
        LinkIdle: begin
          if (i_byte_go) w_state_next = i_dir_tx ? LinkTxDrive : LinkRxWaitH1;
        end
        LinkRxWaitH1: begin
          if (o_rx_valid) begin
            w_hs2_next   = 1'b1;
            w_state_next = LinkRxWaitH1Low;
          end
        end
        LinkRxWaitH1Low: begin
          if (o_byte_done) begin
            w_hs2_next   = 1'b0;
            w_state_next = i_byte_go ? LinkRxWaitH1 : LinkIdle;
          end
        end
        LinkTxDrive: begin
          if (!i_handshake_1) begin
            w_hs2_next   = 1'b1;
            w_state_next = LinkTxWaitAck;
          end
        end
        LinkTxWaitAck: begin
          if (i_handshake_1) begin
            w_hs2_next   = 1'b0;
            w_state_next = LinkTxWaitAckLow;
          end
        end
        LinkTxWaitAckLow: begin
          if (o_byte_done) w_state_next = i_byte_go ? LinkTxDrive : LinkIdle;
        end
        default: w_state_next = LinkIdle;
      endcase
    end
  end

endmodule

// File: rtl/up_packet_controller.sv
// Transaction sequencer: 6-byte command packet in, one register bus access with
// timeout, 8-byte reply (data then status) out over the uP byte handshake.
module up_packet_controller
  import up_packet_controller_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uP_start,
  input  logic                  uP_handshake_1,
  input  logic                  uP_RW,
  input  logic [7:0]            uP_data_in,
  output logic [7:0]            uP_data_out,
  output logic                  uP_data_oe,
  output logic                  uP_handshake_2,
  output logic                  uP_ack,
  output logic                  uP_nFault,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [31:0]           bus_write_data,
  output logic                  bus_read,
  output logic                  bus_write,
  input  logic [31:0]           bus_read_data,
  input  logic                  bus_ack
);

  localparam int unsigned ToW       = $clog2(BUS_TIMEOUT + 1);
  localparam logic [2:0]  LastRxIdx = 3'(NOS_READ_BYTES_FROM_UP - 1);
  localparam logic [2:0]  LastTxIdx = 3'(NOS_WRITE_BYTES_TO_UP - 1);

  pkt_state_e                          r_state, w_state_next;
  logic [2:0]                          r_cnt;
  byte_t [NOS_READ_BYTES_FROM_UP-1:0]  r_packet;
  logic [31:0]                         r_data;
  logic [31:0]                         r_status;
  byte_t                               r_txn_cnt;
  logic [ToW-1:0]                      r_to_cnt;
  logic                                r_ack;
  logic                                r_start_q;

  logic                                w_start_edge;
  logic                                w_rx_valid;
  logic                                w_byte_done;
  logic                                w_byte_go;
  logic                                w_last_byte;
  logic                                w_cmd_read;
  logic                                w_cmd_write;
  logic                                w_cmd_ok;
  logic                                w_bus_done;
  logic                                w_timeout;
  logic [31:0]                         w_wdata;
  byte_t                               w_txn_cnt_now;
  byte_t [NOS_WRITE_BYTES_TO_UP-1:0]   w_reply;
  byte_t                               w_tx_byte;

  assign w_start_edge = uP_start && !r_start_q;

  assign w_cmd_read  = (r_packet[0] == READ_REGISTER_CMD);
  assign w_cmd_write = (r_packet[0] == WRITE_REGISTER_CMD);
  assign w_cmd_ok    = w_cmd_read || w_cmd_write;
  assign w_wdata     = {r_packet[5], r_packet[4], r_packet[3], r_packet[2]};

  // The strobe cycle itself is the first of the BUS_TIMEOUT sampled cycles.
  assign w_bus_done = bus_ack && (((r_state == PktExec) && w_cmd_ok) || (r_state == PktWaitBus));
  assign w_timeout  = (r_state == PktWaitBus) && !bus_ack &&
                      (r_to_cnt == ToW'(BUS_TIMEOUT - 1));

  assign w_txn_cnt_now = (r_state == PktExec) ? r_txn_cnt + 8'd1 : r_txn_cnt;

  assign bus_address    = ADDR_WIDTH'(r_packet[1]);
  assign bus_write_data = w_wdata;
  assign bus_read       = (r_state == PktExec) && w_cmd_read && !w_start_edge;
  assign bus_write      = (r_state == PktExec) && w_cmd_write && !w_start_edge;

  assign w_last_byte = (r_state == PktTx) ? (r_cnt == LastTxIdx) : (r_cnt == LastRxIdx);
  assign w_byte_go   = ((r_state == PktRx) || (r_state == PktTx)) &&
                       !(w_byte_done && w_last_byte);

  assign w_reply   = {r_status, r_data};
  assign w_tx_byte = w_reply[r_cnt];

  assign uP_ack    = r_ack;
  assign uP_nFault = ~(r_status[StatusBusErrBit] | r_status[StatusBadCmdBit]);

  up_packet_controller_byte_link u_byte_link (
    .clk           (clk),
    .reset         (reset),
    .i_abort       (w_start_edge),
    .i_byte_go     (w_byte_go),
    .i_dir_tx      (r_state == PktTx),
    .i_tx_byte     (w_tx_byte),
    .i_handshake_1 (uP_handshake_1),
    .i_rw          (uP_RW),
    .o_rx_valid    (w_rx_valid),
    .o_byte_done   (w_byte_done),
    .o_handshake_2 (uP_handshake_2),
    .o_data_out    (uP_data_out),
    .o_data_oe     (uP_data_oe)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_start_edge) begin
      w_state_next = PktRx;
    end else begin
      unique case (r_state)
        PktIdle:    w_state_next = PktIdle;
        PktRx:      if (w_byte_done && w_last_byte) w_state_next = PktExec;
        PktExec:    w_state_next = (!w_cmd_ok || w_bus_done) ? PktTx : PktWaitBus;
        PktWaitBus: if (w_bus_done || w_timeout) w_state_next = PktTx;
        PktTx:      if (w_byte_done && w_last_byte) w_state_next = PktDone;
        PktDone:    w_state_next = PktIdle;
        default:    w_state_next = PktIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= PktIdle;
      r_cnt     <= 3'd0;
      r_packet  <= '0;
      r_data    <= 32'h0;
      r_status  <= 32'h0;
      r_txn_cnt <= 8'h00;
      r_to_cnt  <= '0;
      r_ack     <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= uP_start;
      if (w_start_edge) begin
        r_cnt <= 3'd0;
        r_ack <= 1'b0;
      end else begin
        if (w_rx_valid && (r_state == PktRx)) r_packet[r_cnt] <= uP_data_in;
        if (w_byte_done) r_cnt <= w_last_byte ? 3'd0 : r_cnt + 3'd1;

        if (r_state == PktExec) begin
          r_txn_cnt <= r_txn_cnt + 8'd1;
          r_to_cnt  <= ToW'(1);
        end else if (r_state == PktWaitBus) begin
          r_to_cnt <= r_to_cnt + ToW'(1);
        end

        if ((r_state == PktExec) && !w_cmd_ok) begin
          r_data   <= 32'h0;
          r_status <= make_status(1'b0, 1'b1, r_packet[1], r_packet[0], w_txn_cnt_now);
        end else if (w_bus_done) begin
          r_data   <= w_cmd_read ? bus_read_data : w_wdata;
          r_status <= make_status(1'b0, 1'b0, r_packet[1], r_packet[0], w_txn_cnt_now);
        end else if (w_timeout) begin
          r_data   <= 32'h0;
          r_status <= make_status(1'b1, 1'b0, r_packet[1], r_packet[0], w_txn_cnt_now);
        end

        if (r_state == PktDone) r_ack <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_up_packet_controller.sv
// Directed bench for up_packet_controller: table of full transactions plus
// hand-written timeout, abort and reset-during-reply sequences.
module tb_up_packet_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        uP_start, uP_handshake_1, uP_RW;
  logic [7:0]  uP_data_in, uP_data_out;
  logic        uP_data_oe, uP_handshake_2, uP_ack, uP_nFault;
  logic [7:0]  bus_address;
  logic [31:0] bus_write_data, bus_read_data;
  logic        bus_read, bus_write, bus_ack;

  up_packet_controller #(
    .BUS_TIMEOUT (16),
    .ADDR_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uP_start       (uP_start),
    .uP_handshake_1 (uP_handshake_1),
    .uP_RW          (uP_RW),
    .uP_data_in     (uP_data_in),
    .uP_data_out    (uP_data_out),
    .uP_data_oe     (uP_data_oe),
    .uP_handshake_2 (uP_handshake_2),
    .uP_ack         (uP_ack),
    .uP_nFault      (uP_nFault),
    .bus_address    (bus_address),
    .bus_write_data (bus_write_data),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_read_data  (bus_read_data),
    .bus_ack        (bus_ack)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          strobe_cyc = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_wdata = 32'h0;
  int          ack_dly = -1;
  logic [31:0] rd_val = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts every cycle a strobe is high, so a stuck strobe shows as extra pulses.
  always @(negedge clk) begin
    if (bus_read)  n_rd <= n_rd + 1;
    if (bus_write) n_wr <= n_wr + 1;
    if (bus_read || bus_write) begin
      strobe_cyc <= cyc;
      last_addr  <= bus_address;
      last_wdata <= bus_write_data;
    end
  end

  // Register-bus slave: acks ack_dly cycles after the strobe cycle; -1 never acks.
  initial begin
    bus_ack       = 1'b0;
    bus_read_data = 32'h0;
    forever begin
      @(negedge clk);
      if ((bus_read || bus_write) && ack_dly >= 0) begin
        repeat (ack_dly) @(negedge clk);
        bus_read_data = rd_val;
        bus_ack       = 1'b1;
        @(negedge clk);
        bus_ack       = 1'b0;
        bus_read_data = 32'h0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return uP_handshake_2;
      1:       return uP_nFault;
      2:       return uP_ack;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input string what);
    int i;
    for (i = 0; i < 100; i++) begin
      if (pick(sel) === val) break;
      @(negedge clk);
    end
    if (i == 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_%s: stuck at %b, required %b", what, pick(sel), val);
    end
  endtask

  task automatic start_pulse();
    uP_start = 1'b1;
    @(negedge clk);
    uP_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uP_data_in     = b;
    uP_RW          = 1'b1;
    uP_handshake_1 = 1'b1;
    @(negedge clk);
    wait_for(0, 1'b1, "rx_hs2_hi");
    uP_handshake_1 = 1'b0;
    @(negedge clk);
    wait_for(0, 1'b0, "rx_hs2_lo");
  endtask

  task automatic send_packet(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [31:0] wd);
    send_byte(cmd);
    send_byte(addr);
    for (int k = 0; k < 4; k++) send_byte(wd[8*k +: 8]);
    uP_RW = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    uP_handshake_1 = 1'b0;
    wait_for(0, 1'b1, "tx_hs2_hi");
    chk("oe_during_tx", 64'(uP_data_oe), 64'd1);
    b = uP_data_out;
    uP_handshake_1 = 1'b1;
    @(negedge clk);
    wait_for(0, 1'b0, "tx_hs2_lo");
    uP_handshake_1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic recv_reply(output logic [63:0] reply);
    logic [7:0] b;
    reply = '0;
    for (int k = 0; k < 8; k++) begin
      recv_byte(b);
      reply[8*k +: 8] = b;
    end
    wait_for(2, 1'b1, "uP_ack");
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] wd,
                         output logic [63:0] reply);
    start_pulse();
    send_packet(cmd, addr, wd);
    recv_reply(reply);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdv;
    logic [31:0] exp_data;
    logic [31:0] exp_status;
    logic        exp_nf;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [63:0] reply;
    logic [7:0]  b;
    int          rd0, wr0;

    reset = 1'b0;
    uP_start = 1'b0;
    uP_handshake_1 = 1'b0;
    uP_RW = 1'b0;
    uP_data_in = 8'h00;

    //          cmd    addr   wdata         dly rdv           data          status        nf rd wr
    vecs[0] = '{8'h01, 8'h05, 32'hDEADBEEF, 3,  32'h0,        32'hDEADBEEF, 32'h01010500, 1, 0, 1};
    vecs[1] = '{8'h00, 8'h10, 32'h0,        0,  32'h12345678, 32'h12345678, 32'h02001000, 1, 1, 0};
    vecs[2] = '{8'h00, 8'hFF, 32'h0,        -1, 32'h0,        32'h0,        32'h0300FF01, 0, 1, 0};
    vecs[3] = '{8'h00, 8'h20, 32'h0,        15, 32'hA5A55A5A, 32'hA5A55A5A, 32'h04002000, 1, 1, 0};
    vecs[4] = '{8'h07, 8'h33, 32'h0,        0,  32'h0,        32'h0,        32'h05073302, 0, 0, 0};
    vecs[5] = '{8'h00, 8'h44, 32'h0,        16, 32'h99999999, 32'h0,        32'h06004401, 0, 1, 0};
    vecs[6] = '{8'h01, 8'h7F, 32'h01020304, 1,  32'h0,        32'h01020304, 32'h07017F00, 1, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({uP_data_out, uP_data_oe, uP_handshake_2, uP_ack, bus_read,
                              bus_write, uP_nFault}), 64'({8'h00, 6'b000001}));
    chk("reset_bus", 64'({bus_address, bus_write_data}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      rd0 = n_rd;
      wr0 = n_wr;
      ack_dly = vecs[i].dly;
      rd_val = vecs[i].rdv;
      run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, reply);
      chk($sformatf("v%0d_data", i), 64'(reply[31:0]), 64'(vecs[i].exp_data));
      chk($sformatf("v%0d_status", i), 64'(reply[63:32]), 64'(vecs[i].exp_status));
      chk($sformatf("v%0d_nfault", i), 64'(uP_nFault), 64'(vecs[i].exp_nf));
      chk($sformatf("v%0d_ack_oe", i), 64'({uP_ack, uP_data_oe}), 64'(2'b10));
      chk($sformatf("v%0d_reads", i), 64'(n_rd - rd0), 64'(vecs[i].exp_rd));
      chk($sformatf("v%0d_writes", i), 64'(n_wr - wr0), 64'(vecs[i].exp_wr));
      if (vecs[i].exp_rd + vecs[i].exp_wr > 0)
        chk($sformatf("v%0d_addr", i), 64'(last_addr), 64'(vecs[i].addr));
      if (vecs[i].exp_wr > 0)
        chk($sformatf("v%0d_wdata", i), 64'(last_wdata), 64'(vecs[i].wdata));
    end

    // Unmapped read: error must appear exactly 16 cycles after the strobe.
    chk("nf_before_timeout", 64'(uP_nFault), 64'd1);
    ack_dly = -1;
    start_pulse();
    send_packet(8'h00, 8'hFF, 32'h0);
    wait_for(1, 1'b0, "nfault_lo");
    chk("timeout_cycles", 64'(cyc - strobe_cyc), 64'd16);
    recv_reply(reply);
    chk("timeout_data", 64'(reply[31:0]), 64'h0);
    chk("timeout_status", 64'(reply[63:32]), 64'h0800FF01);

    // Abort after three command bytes; only the restarted packet reaches the bus.
    rd0 = n_rd;
    wr0 = n_wr;
    ack_dly = 2;
    start_pulse();
    send_byte(8'h01);
    send_byte(8'h09);
    send_byte(8'h11);
    uP_RW = 1'b0;
    run_txn(8'h01, 8'h0A, 32'hCAFEF00D, reply);
    chk("abort_writes", 64'(n_wr - wr0), 64'd1);
    chk("abort_reads", 64'(n_rd - rd0), 64'd0);
    chk("abort_addr", 64'(last_addr), 64'h0A);
    chk("abort_wdata", 64'(last_wdata), 64'hCAFEF00D);
    chk("abort_data", 64'(reply[31:0]), 64'hCAFEF00D);
    chk("abort_status", 64'(reply[63:32]), 64'h09010A00);
    chk("abort_nfault", 64'(uP_nFault), 64'd1);

    // Bad command, then reset while reply byte 4 is on the pins.
    start_pulse();
    send_packet(8'h07, 8'h33, 32'h0);
    for (int k = 0; k < 4; k++) recv_byte(b);
    uP_handshake_1 = 1'b0;
    wait_for(0, 1'b1, "tx4_hs2_hi");
    chk("tx4_byte", 64'(uP_data_out), 64'h02);
    chk("tx4_oe", 64'(uP_data_oe), 64'd1);
    chk("tx4_nfault", 64'(uP_nFault), 64'd0);
    uP_RW = 1'b1;
    #1;
    chk("rw_forces_oe_off", 64'(uP_data_oe), 64'd0);
    uP_RW = 1'b0;
    #1;
    chk("rw_low_oe_back", 64'(uP_data_oe), 64'd1);
    reset = 1'b0;
    #1;
    chk("midtx_reset", 64'({uP_data_oe, uP_handshake_2, uP_ack, uP_nFault}), 64'(4'b0001));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    ack_dly = 0;
    rd_val = 32'h0BADF00D;
    run_txn(8'h00, 8'h10, 32'h0, reply);
    chk("post_reset_data", 64'(reply[31:0]), 64'h0BADF00D);
    chk("post_reset_status", 64'(reply[63:32]), 64'h01001000);
    chk("post_reset_nfault", 64'(uP_nFault), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_packet_controller.md
Name: uP_packet_controller

Overview:
Transaction sequencer between the synchronised uP byte-handshake port and the internal 32-bit register bus of motion_system. Each transaction:
- receives a 6-byte command packet: cmd, address, data[7:0] .. data[31:24];
- performs one register read or write, with timeout;
- returns an 8-byte reply: data bytes 0-3, then status bytes 4-7, LSB first.

It drives uP_ack, uP_handshake_2, uP_nFault and the tri-state data enable. Input synchronisers live upstream.

Parameters:
NOS_READ_BYTES_FROM_UP, 6, bytes per command packet
NOS_WRITE_BYTES_TO_UP, 8, bytes per reply packet
BUS_TIMEOUT, 16, clk cycles to wait for bus_ack before flagging an error
ADDR_WIDTH, 8, register address width

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
uP_start  in  1  synchronised start; rising edge begins a transaction
uP_handshake_1  in  1  synchronised uP strobe/ack
uP_RW  in  1  synchronised direction; 1 = uP writes to FPGA
uP_data_in  in  8  byte from the uP data pins
uP_data_out  out  8  byte to the uP data pins
uP_data_oe  out  1  tri-state enable for uP_data_out
uP_handshake_2  out  1  FPGA strobe/ack
uP_ack  out  1  transaction complete
uP_nFault  out  1  0 = last transaction had an error
bus_address  out  ADDR_WIDTH  register address
bus_write_data  out  32  register write data
bus_read  out  1  one-cycle read strobe
bus_write  out  1  one-cycle write strobe
bus_read_data  in  32  register read data, valid with bus_ack
bus_ack  in  1  asserted only on an address-decode hit

Behaviour:
- Reset (async, reset=0):
  - all outputs 0, except uP_nFault=1;
  - state S_IDLE, byte counter 0, packet and status registers cleared.
- Start edge: detected as uP_start=1 with the previous sample 0.
  - Clears uP_ack and the byte counter, then enters S_RX_WAIT_H1.
  - The same edge in any other state aborts the current transaction: no bus strobe if not yet issued, oe=0, handshake_2=0, restart reception.
- RX, per byte:
  - S_RX_WAIT_H1: wait for handshake_1=1 and RW=1.
  - Latch uP_data_in into packet[cnt] and set handshake_2=1 in the same cycle.
  - S_RX_WAIT_H1_LOW: wait for handshake_1=0, clear handshake_2, cnt++.
  - After byte 5 go to S_EXEC. No ordering on RW deassertion is required.
- S_EXEC, one cycle:
  - cmd 0: bus_read=1.
  - cmd 1: bus_write=1, with bus_write_data = {p5,p4,p3,p2}.
  - Any other cmd: no strobe, BAD_CMD=1, go directly to S_TX.
  - bus_address = p1 in all cases.
- S_WAIT_BUS:
  - Timeout counter starts at 0. A bus_ack on the strobe cycle counts.
  - On ack: read captures bus_read_data; write returns the written data.
  - If no ack within BUS_TIMEOUT cycles: data=0, BUS_ERR=1.
  - bus_address and bus_write_data hold until leaving the state.
- Status word:
  - bit0 BUS_ERR, bit1 BAD_CMD, bits7:2 = 0;
  - bits15:8 address echo, bits23:16 cmd echo;
  - bits31:24 transaction count, 8-bit wrap, incremented at S_EXEC.
- uP_nFault = ~(BUS_ERR|BAD_CMD), updated when leaving S_WAIT_BUS (or S_EXEC for a bad cmd), held until the next such update.
- TX, per byte:
  - S_TX_DRIVE: uP_data_out = reply[cnt]; uP_data_oe = (RW==0); wait for handshake_1=0, then handshake_2=1.
  - S_TX_WAIT_ACK: wait for handshake_1=1, clear handshake_2.
  - S_TX_WAIT_ACK_LOW: wait for handshake_1=0, cnt++.
  - After byte 7: oe=0, go to S_DONE.
- S_DONE: uP_ack=1, held in S_IDLE until the next start edge.
- If RW=1 while in TX, oe is forced to 0 on that same cycle, so there is never bus contention.

Decomposition:
- Package types holds:
  - byte_t;
  - the cmd enum: READ_REGISTER_CMD=0, WRITE_REGISTER_CMD=1;
  - the state enum;
  - status bit positions;
  - NOS_READ_BYTES_FROM_UP and NOS_WRITE_BYTES_TO_UP.
- One sub-module, uP_byte_link: the per-byte RX/TX handshake FSM, with byte_done/byte_go to the packet FSM.

Test Plan:
- Write: cmd 1, addr 0x05, 0xDEADBEEF, with the bench acking in 3 cycles → one bus_write pulse with addr 5, data DEADBEEF. Reply data = DEADBEEF; status = 0x00010500 | count<<24; nFault=1; uP_ack=1.
- Read: cmd 0, addr 0x10, bench returns 0x12345678 → reply bytes 78 56 34 12, then status; bus_read pulses once.
- Unmapped: cmd 0, addr 0xFF, no bus_ack → error flagged after exactly 16 cycles. Data=0, status bit0=1, nFault=0. The next good transaction restores nFault=1.
- Bad cmd 0x07 → no bus strobe, status bit1=1, nFault=0.
- Abort: new start edge after RX byte 3 → no bus strobe; the following full packet completes correctly.
- Reset asserted mid-TX (byte 4) → oe, handshake_2 and uP_ack go 0 immediately, nFault=1, and the FSM returns to S_IDLE.
